// File: rtl/duckhunt_fire_pkg.sv
// Shared definitions for the firing controller and the datapath.
// Contents: datapath control encodings, firing FSM state type and the
// state-to-control decode used by the controller.
package duckhunt_fire_pkg;

  localparam logic [2:0] CTRL_RELOAD = 3'b000;
  localparam logic [2:0] CTRL_HOLD   = 3'b001;
  localparam logic [2:0] CTRL_SHOT   = 3'b011;

  typedef enum logic [1:0] {
    READY,
    SHOT,
    COOLDOWN,
    WAIT_RELEASE
  } fire_state_t;

  function automatic logic [2:0] ctrl_decode(input fire_state_t s);
    case (s)
      READY:   return CTRL_RELOAD;
      SHOT:    return CTRL_SHOT;
      default: return CTRL_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Trigger input conditioning: 2-flop synchroniser, debouncer and press pulse.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   trigger_n in   raw active-low push-button, asynchronous to clk
//   pressed   out  debounced level, 1 = button held
//   press     out  1-cycle pulse, coincident with the released->pressed flip
module trigger_debounce
  import duckhunt_fire_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_n;
  logic [CW-1:0] cnt;
  logic          flip;

  // Synced level has differed from the debounced level for DEBOUNCE_CYCLES
  // consecutive cycles; the level flips on the coming edge.
  assign flip    = (sync_q2 != level_n) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press   = flip & ~sync_q2;
  assign pressed = ~level_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level_n <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_q1 <= trigger_n;
      sync_q2 <= sync_q1;
      if (sync_q2 == level_n) begin
        cnt <= '0;
      end else if (flip) begin
        level_n <= sync_q2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/firing_control.sv
// Firing controller: turns the trigger button into datapath control codes,
// one SHOT per press, followed by a cooldown and a wait for release.
// Optional build macro: FIRING_CONTROL_AUTOFIRE_EN (held button re-fires
// from WAIT_RELEASE while round_active is high).
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   trigger_n    in   raw active-low push-button
//   round_active in   shooting allowed
//   leave        in   round-end pulse, synchronous abort to READY
//   control      out  datapath command (RELOAD/HOLD/SHOT)
//   flash        out  muzzle-flash enable
//   armed        out  high only in READY
module firing_control
  import duckhunt_fire_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned COOLDOWN_CYCLES = 12500000,
  parameter int unsigned FLASH_CYCLES    = 2500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       trigger_n,
  input  logic       round_active,
  input  logic       leave,
  output logic [2:0] control,
  output logic       flash,
  output logic       armed
);

  localparam int unsigned CCW = $clog2(COOLDOWN_CYCLES + 1);
  localparam int unsigned FCW = $clog2(FLASH_CYCLES + 1);

  fire_state_t    state;
  fire_state_t    state_nx;
  logic [CCW-1:0] cool_cnt;
  logic [FCW-1:0] flash_cnt;
  logic           pressed;
  logic           press;
  logic           cool_done;

  trigger_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .trigger_n(trigger_n),
    .pressed  (pressed),
    .press    (press)
  );

  assign cool_done = (cool_cnt == CCW'(COOLDOWN_CYCLES - 1));

  always_comb begin
    state_nx = state;
    case (state)
      READY:        if (press) state_nx = round_active ? SHOT : WAIT_RELEASE;
      SHOT:         state_nx = COOLDOWN;
      COOLDOWN:     if (cool_done) state_nx = WAIT_RELEASE;
      WAIT_RELEASE: begin
`ifdef FIRING_CONTROL_AUTOFIRE_EN
        if (!pressed)          state_nx = READY;
        else if (round_active) state_nx = SHOT;
`else
        if (!pressed) state_nx = READY;
`endif
      end
      default:      state_nx = READY;
    endcase
    if (leave) state_nx = READY;
  end

  // Outputs decode the next state so they change with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= READY;
      control   <= CTRL_RELOAD;
      flash     <= 1'b0;
      armed     <= 1'b1;
      cool_cnt  <= '0;
      flash_cnt <= '0;
    end else begin
      state   <= state_nx;
      control <= ctrl_decode(state_nx);
      armed   <= (state_nx == READY);

      if (state == COOLDOWN && !cool_done && !leave) cool_cnt <= cool_cnt + 1'b1;
      else                                           cool_cnt <= '0;

      if (leave) begin
        flash     <= 1'b0;
        flash_cnt <= '0;
      end else if (state_nx == SHOT) begin
        flash     <= 1'b1;
        flash_cnt <= FCW'(1);
      end else if (flash) begin
        if (flash_cnt >= FCW'(FLASH_CYCLES)) begin
          flash     <= 1'b0;
          flash_cnt <= '0;
        end else begin
          flash_cnt <= flash_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_firing_control.sv
`timescale 1ns/1ps
module tb_firing_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       trigger_n;
  logic       round_active;
  logic       leave;
  logic [2:0] control;
  logic       flash;
  logic       armed;

  int checks   = 0;
  int failures = 0;
  int shots;
  int pos[$];

  always #5 clk = ~clk;

  firing_control #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .FLASH_CYCLES   (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trigger_n   (trigger_n),
    .round_active(round_active),
    .leave       (leave),
    .control     (control),
    .flash       (flash),
    .armed       (armed)
  );

  // One record per cycle: outputs expected just after the edge, then the
  // inputs driven for the following edge.
  typedef struct {
    logic       trig_n;
    logic       ra;
    logic       lv;
    logic [2:0] ctrl;
    logic       fl;
    logic       arm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic t, input logic ra, input logic lv,
                     input logic [2:0] c, input logic f, input logic a);
    vec_t v;
    v.trig_n = t; v.ra = ra; v.lv = lv; v.ctrl = c; v.fl = f; v.arm = a;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Press at k=0 held to k=19 with round_active: SHOT at k=6, cooldown
  // k=7..14, flash k=6..8, release at k=20, READY at k=27.
  task automatic add_press_shot();
    add(6,  1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1,  1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
    add(2,  1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    add(11, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(7,  1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(2,  1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
  endtask

  // Press without round_active: discarded into WAIT_RELEASE at k=6.
  task automatic add_press_noshot();
    add(6, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    add(4, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    add(7, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    add(2, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    trigger_n    = 1'b1;
    round_active = 1'b1;
    leave        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl",  int'(control), 0);
    chk("reset_flash", int'(flash),   0);
    chk("reset_armed", int'(armed),   1);
    reset_n = 1'b1;
    repeat (3) tick();

    add_press_shot();
    for (int i = 0; i < 30; i++)
      add(1, ((i / 2) % 2) == 1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    add(6, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    add_press_noshot();
    add_press_shot();

    foreach (vecs[i]) begin
      tick();
      chk($sformatf("vec%0d_ctrl", i),  int'(control), int'(vecs[i].ctrl));
      chk($sformatf("vec%0d_flash", i), int'(flash),   int'(vecs[i].fl));
      chk($sformatf("vec%0d_armed", i), int'(armed),   int'(vecs[i].arm));
      trigger_n    = vecs[i].trig_n;
      round_active = vecs[i].ra;
      leave        = vecs[i].lv;
    end

    // leave in the 3rd cooldown cycle with the button held
    trigger_n = 1'b0;
    round_active = 1'b1;
    repeat (9) tick();
    chk("cool3_ctrl", int'(control), 1);
    leave = 1'b1;
    tick();
    chk("leave_ctrl",  int'(control), 0);
    chk("leave_flash", int'(flash),   0);
    chk("leave_armed", int'(armed),   1);
    leave = 1'b0;
    shots = 0;
    repeat (20) begin
      tick();
      if (control == 3'b011) shots++;
    end
    chk("held_after_leave_shots", shots, 0);
    trigger_n = 1'b1;
    repeat (10) tick();
    chk("rel_after_leave_ctrl", int'(control), 0);
    trigger_n = 1'b0;
    repeat (6) tick();
    chk("repress_ctrl",  int'(control), 3);
    chk("repress_flash", int'(flash),   1);
    repeat (20) tick();
    trigger_n = 1'b1;
    repeat (10) tick();
    chk("repress_done_ctrl",  int'(control), 0);
    chk("repress_done_armed", int'(armed),   1);

    // press pulse and leave in the same cycle
    trigger_n = 1'b0;
    repeat (5) tick();
    leave = 1'b1;
    tick();
    chk("coinc_ctrl",  int'(control), 0);
    chk("coinc_armed", int'(armed),   1);
    leave = 1'b0;
    shots = 0;
    repeat (15) begin
      tick();
      if (control == 3'b011) shots++;
    end
    chk("coinc_shots", shots, 0);
    chk("coinc_ready", int'(armed), 1);
    trigger_n = 1'b1;
    repeat (10) tick();

    // long hold: one shot, or autofire every COOLDOWN_CYCLES+2
    trigger_n = 1'b0;
    pos.delete();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (control == 3'b011) pos.push_back(k);
    end
    trigger_n = 1'b1;
`ifdef FIRING_CONTROL_AUTOFIRE_EN
    chk("hold_shot_count", pos.size(), 4);
`else
    chk("hold_shot_count", pos.size(), 1);
`endif
    if (pos.size() >= 1) chk("hold_first_shot", pos[0], 6);
    for (int j = 1; j < pos.size(); j++)
      chk($sformatf("hold_spacing%0d", j), pos[j] - pos[j-1], 10);
    repeat (25) tick();
    chk("hold_done_ctrl",  int'(control), 0);
    chk("hold_done_armed", int'(armed),   1);

    // asynchronous reset in the middle of a cooldown
    trigger_n = 1'b0;
    repeat (8) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl",  int'(control), 0);
    chk("async_rst_flash", int'(flash),   0);
    chk("async_rst_armed", int'(armed),   1);
    trigger_n = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_ctrl", int'(control), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/firing_control.md
Name: firing_control

Overview:
Upstream controller for the firing datapath. It turns the player's raw trigger button into the 3-bit `control` code that the datapath consumes. It synchronises and debounces the button, issues exactly one single-cycle SHOT per press, enforces a cooldown, and waits for button release before re-arming. It also drives a muzzle-flash strobe for the VGA renderer.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles (10 ms at 50 MHz) required to accept a new trigger level.
- COOLDOWN_CYCLES, 12500000: cycles (250 ms) spent in COOLDOWN after each shot.
- FLASH_CYCLES, 2500000: cycles `flash` stays high after a shot; must be ≤ COOLDOWN_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- trigger_n  in  1  raw push-button, active-low, asynchronous to clk.
- round_active  in  1  high while a bird is on screen and shooting is allowed.
- leave  in  1  round-end pulse (same signal the datapath sees); synchronous abort here.
- control  out  3  datapath command: 3'b000 RELOAD, 3'b001 HOLD, 3'b011 SHOT.
- flash  out  1  muzzle-flash enable for renderer.
- armed  out  1  high only in state READY (crosshair colour cue).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - control=3'b000, flash=0, armed=1.
  - FSM=READY; debounced level=released; all counters 0; synchroniser flops=1.
- Input path:
  - 2-flop synchroniser on trigger_n.
  - Debouncer: counter increments while the synced level ≠ debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - `press` is a 1-cycle pulse on the released→pressed transition of the debounced level.
  - Latency from a stable raw edge to `press`: 2 + DEBOUNCE_CYCLES cycles.
- FSM states (registered `control` shown in brackets):
  - READY [000]: on press && round_active → SHOT. A press while !round_active is discarded and goes to WAIT_RELEASE.
  - SHOT [011]: exactly one cycle, unconditionally → COOLDOWN. The datapath decrements once per SHOT cycle, so SHOT must never last 2+ cycles.
  - COOLDOWN [001]: counts COOLDOWN_CYCLES cycles, then → WAIT_RELEASE.
  - WAIT_RELEASE [001]: if debounced level is released → READY on the next cycle; otherwise stay.
- `control` is a registered decode of the next state, so it changes in the same cycle the state register changes.
- flash:
  - Set in the cycle `control` becomes SHOT.
  - Held for FLASH_CYCLES cycles total, then cleared.
  - A new SHOT restarts the flash counter.
- leave (synchronous, highest priority after reset):
  - → READY; control=000; flash=0; cooldown and flash counters cleared.
  - Debouncer state is kept.
  - A press coincident with leave is dropped, with no SHOT.
  - If the button is still held after leave, `press` does not re-fire until a release and a new press.
- round_active falling mid-COOLDOWN has no effect; the sequence completes.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.
- Release bounces shorter than DEBOUNCE_CYCLES produce no press.

Optional Feature:
- Macro FIRING_CONTROL_AUTOFIRE_EN.
- Defined: in WAIT_RELEASE, if the button is still held and round_active=1, go directly to SHOT (repeat fire every COOLDOWN_CYCLES+2 cycles). Release behaves as normal.
- Undefined: one shot per press, exactly as described above.

Decomposition:
- Package duckhunt_fire_pkg:
  - control encodings CTRL_RELOAD=3'b000, CTRL_HOLD=3'b001, CTRL_SHOT=3'b011.
  - FSM state enum {READY, SHOT, COOLDOWN, WAIT_RELEASE}.
  - The datapath shares the control encodings.
- Sub-module trigger_debounce (synchroniser + debouncer + press pulse), parameter DEBOUNCE_CYCLES. The FSM stays in firing_control.

Test Plan (bench params DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, FLASH_CYCLES=3):
- Reset, then a clean press held 20 cycles with round_active=1 → control=011 for exactly 1 cycle, 6 cycles after the raw edge; then 001 for 8 cycles; flash high 3 cycles; after release+6 cycles, control=000 and armed=1.
- Raw trigger toggling every 2 cycles for 30 cycles → no SHOT, control stays 000.
- Press with round_active=0 → no SHOT. A release then press with round_active=1 → one SHOT.
- leave asserted in the 3rd COOLDOWN cycle with the button held → next cycle control=000, flash=0. No further SHOT until release and re-press.
- Press edge and leave in the same cycle → no SHOT; state READY.
- With FIRING_CONTROL_AUTOFIRE_EN, hold for 40 cycles → SHOT cycles spaced 10 cycles apart. Without it → exactly one SHOT.
